// File: rtl/fb_writer_pkg.sv
// Shared types and constants for the framebuffer pixel writer.
// The CLEAR state exists only when FB_WRITER_CLEAR_EN is defined.
package fb_writer_pkg;

    localparam int FB_ADDR_W     = 15;
    localparam int COLOUR_W      = 3;
    localparam int COORD_W       = 10;
    localparam int FB_WIDTH_DEF  = 160;
    localparam int FB_HEIGHT_DEF = 120;
    localparam int ENTRY_W       = FB_ADDR_W + COLOUR_W;

`ifdef FB_WRITER_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } fb_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1
    } fb_state_e;
`endif

    // One buffered pixel: linear framebuffer address plus colour (18 bits).
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOUR_W-1:0]  colour;
    } fb_entry_t;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Small synchronous FIFO of pixel entries; head is visible combinationally.
// The caller never pushes into a full FIFO without a same-cycle pop, nor pops when empty.
module fb_pixel_fifo
    import fb_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  logic      pop,
    input  fb_entry_t din,
    output fb_entry_t head,
    output logic      full,
    output logic      empty,
    output logic      single
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head   = mem[rd_ptr];
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign single = (count == (AW+1)'(1));

endmodule

// File: rtl/fb_writer.sv
// Buffers pixel strobes in a FIFO and drains them to a framebuffer write port.
// Define FB_WRITER_CLEAR_EN to add the whole-framebuffer fill (CLEAR) feature.
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH_DEF,
    parameter int HEIGHT = FB_HEIGHT_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 writeEn,
    input  logic [COORD_W-1:0]   x_in,
    input  logic [COORD_W-1:0]   y_in,
    input  logic [COLOUR_W-1:0]  colour,
    output logic                 full,
    output logic                 overflow,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [COLOUR_W-1:0]  mem_data,
    input  logic                 mem_ready,
`ifdef FB_WRITER_CLEAR_EN
    input  logic                 clear_req,
    input  logic [COLOUR_W-1:0]  bg_colour,
    output logic                 clear_done,
`endif
    output logic                 busy,
    output fb_state_e            state_dbg
);

    // Write handshake: a write transfers on every rising edge where mem_we and
    // mem_ready are both high; while mem_ready is low, mem_we/addr/data hold.

    fb_state_e            state, state_nxt;
    fb_entry_t            head, push_entry;
    logic                 fifo_empty, fifo_single;
    logic                 in_range, push, pop;
    logic [FB_ADDR_W-1:0] push_addr;

    assign in_range   = (x_in < COORD_W'(WIDTH)) && (y_in < COORD_W'(HEIGHT));
    assign push_addr  = FB_ADDR_W'(32'(y_in) * 32'(WIDTH) + 32'(x_in));
    assign push_entry = '{addr: push_addr, colour: colour};

    // A full FIFO still takes a pixel when the head leaves in the same cycle.
    assign pop  = (state == ST_DRAIN) && mem_ready && !fifo_empty;
    assign push = writeEn && in_range && (!full || pop);

    fb_pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (push_entry),
        .head   (head),
        .full   (full),
        .empty  (fifo_empty),
        .single (fifo_single)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (writeEn && in_range && full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef FB_WRITER_CLEAR_EN
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WIDTH * HEIGHT - 1);

    logic [FB_ADDR_W-1:0] clr_cnt;
    logic                 clear_pend, clr_last, clear_go;

    assign clr_last = (clr_cnt == LAST_ADDR);
    assign clear_go = clear_req || clear_pend;

    // A clear requested mid-drain waits for the presented head write to finish.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_cnt    <= '0;
            clear_pend <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= (state == ST_CLEAR) && mem_ready && clr_last;
            clear_pend <= (state == ST_DRAIN) && !pop && clear_go;
            if (state == ST_CLEAR && mem_ready) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        case (state)
            ST_IDLE: begin
`ifdef FB_WRITER_CLEAR_EN
                if (clear_req)                  state_nxt = ST_CLEAR;
                else if (!fifo_empty || push)   state_nxt = ST_DRAIN;
`else
                if (!fifo_empty || push)        state_nxt = ST_DRAIN;
`endif
            end
            ST_DRAIN: begin
                mem_we   = !fifo_empty;
                mem_addr = head.addr;
                mem_data = head.colour;
`ifdef FB_WRITER_CLEAR_EN
                if (pop && clear_go)                      state_nxt = ST_CLEAR;
                else if (pop && fifo_single && !push)     state_nxt = ST_IDLE;
`else
                if (pop && fifo_single && !push)          state_nxt = ST_IDLE;
`endif
            end
`ifdef FB_WRITER_CLEAR_EN
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_cnt;
                mem_data = bg_colour;
                if (mem_ready && clr_last) begin
                    state_nxt = (!fifo_empty || push) ? ST_DRAIN : ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign state_dbg = state;

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: queue-based reference model plus directed literals.
// Fill-feature scenarios run only when FB_WRITER_CLEAR_EN is defined.
module tb_fb_writer;
    import fb_writer_pkg::*;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int D    = 4;
    localparam int LAST = W * H - 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        writeEn;
    logic [9:0]  x_in, y_in;
    logic [2:0]  colour;
    logic        full, overflow, mem_we, mem_ready, busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        clear_req;
    logic [2:0]  bg_colour;
    fb_state_e   state_dbg;
`ifdef FB_WRITER_CLEAR_EN
    logic        clear_done;
`endif

    always #5 clk = ~clk;

    fb_writer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .writeEn    (writeEn),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour     (colour),
        .full       (full),
        .overflow   (overflow),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
`ifdef FB_WRITER_CLEAR_EN
        .clear_req  (clear_req),
        .bg_colour  (bg_colour),
        .clear_done (clear_done),
`endif
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    int tests = 0;
    int fails = 0;

    // Model: pixels accepted but not yet written, plus fill progress.
    logic [17:0] exp_q[$];
    logic        m_ovf, m_clearing, m_wait, m_done;
    int          m_idx;

    // Observed DUT writes.
    int          wr_count;
    bit          log_en, done_seen;
    logic [17:0] wr_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 0; m_clearing = 0; m_wait = 0; m_done = 0; m_idx = 0;
    endtask

    task automatic compare_outputs();
        logic        e_we;
        logic [14:0] e_addr;
        logic [2:0]  e_data;
        if (m_clearing) begin
            e_we = 1; e_addr = 15'(m_idx); e_data = bg_colour;
        end else if (exp_q.size() > 0) begin
            e_we = 1; e_addr = exp_q[0][17:3]; e_data = exp_q[0][2:0];
        end else begin
            e_we = 0; e_addr = '0; e_data = '0;
        end
        check("mem_we",   32'(mem_we),   32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_data", 32'(mem_data), 32'(e_data));
        check("full",     32'(full),     32'(exp_q.size() == D));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy",     32'(busy),     32'(m_clearing || exp_q.size() > 0));
`ifdef FB_WRITER_CLEAR_EN
        check("clear_done", 32'(clear_done), 32'(m_done));
        if (clear_done) done_seen = 1;
`endif
        if (mem_we && mem_ready) begin
            wr_count++;
            if (log_en) wr_log.push_back({mem_addr, mem_data});
        end
    endtask

    task automatic model_edge();
        bit pix_pop, inr, acc;
        pix_pop = !m_clearing && exp_q.size() > 0 && mem_ready;
        inr     = (int'(x_in) < W) && (int'(y_in) < H);
        acc     = writeEn && inr && (exp_q.size() < D || pix_pop);
        if (writeEn && inr && !acc) m_ovf = 1;
        m_done = m_clearing && mem_ready && m_idx == LAST;
        if (m_clearing) begin
            if (mem_ready) begin
                if (m_idx == LAST) begin m_clearing = 0; m_idx = 0; end
                else m_idx++;
            end
        end else if (clear_req || m_wait) begin
            if (exp_q.size() == 0 || pix_pop) begin m_clearing = 1; m_wait = 0; end
            else m_wait = 1;
        end
        if (pix_pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({15'(int'(y_in) * W + int'(x_in)), colour});
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        #1;
        compare_outputs();
        model_edge();
        @(negedge clk);
    endtask

    task automatic strobe(input int x, input int y, input int c);
        writeEn = 1; x_in = 10'(x); y_in = 10'(y); colour = 3'(c);
        step();
        writeEn = 0;
    endtask

    task automatic apply_reset();
        resetn = 0;
        #1;
        model_reset();
        check("rst_mem_we",    32'(mem_we),   0);
        check("rst_mem_addr",  32'(mem_addr), 0);
        check("rst_mem_data",  32'(mem_data), 0);
        check("rst_full",      32'(full),     0);
        check("rst_overflow",  32'(overflow), 0);
        check("rst_busy",      32'(busy),     0);
`ifdef FB_WRITER_CLEAR_EN
        check("rst_clear_done", 32'(clear_done), 0);
`endif
        @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        int n, base;
        resetn = 0; writeEn = 0; x_in = '0; y_in = '0; colour = '0;
        mem_ready = 0; clear_req = 0; bg_colour = '0;
        wr_count = 0; log_en = 0; done_seen = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single pixel: address 2*160+5 = 325 on the cycle after acceptance.
        mem_ready = 1;
        strobe(5, 2, 2);
        #1;
        check("p1_model_depth", 32'(exp_q.size()), 1);
        check("p1_we",   32'(mem_we),   1);
        check("p1_addr", 32'(mem_addr), 325);
        check("p1_data", 32'(mem_data), 2);
        step();
        #1;
        check("p1_idle_we",   32'(mem_we), 0);
        check("p1_idle_busy", 32'(busy),   0);

        // Out-of-range pixel is dropped silently.
        strobe(160, 0, 7);
        #1;
        check("oor_we",       32'(mem_we),   0);
        check("oor_overflow", 32'(overflow), 0);

        // Six strobes against a stalled port: four kept, two dropped.
        mem_ready = 0;
        for (int i = 0; i < 6; i++) begin
            strobe(i, 0, i);
            if (i == 3) begin
                #1;
                check("full_after_4", 32'(full), 1);
            end
        end
        #1;
        check("ovf_after_6", 32'(overflow), 1);
        wr_log.delete(); log_en = 1; mem_ready = 1;
        repeat (8) step();
        log_en = 0;
        check("burst_writes", 32'(wr_log.size()), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++)
            check("burst_order", 32'(wr_log[k]), 32'({15'(k), 3'(k)}));

        // Reset while draining three buffered pixels.
        apply_reset();
        mem_ready = 0;
        strobe(10, 10, 1); strobe(11, 10, 2); strobe(12, 10, 3);
        step();
        check("pre_rst_model_depth", 32'(exp_q.size()), 3);
        apply_reset();
        base = wr_count; mem_ready = 1;
        repeat (5) step();
        check("post_rst_writes", 32'(wr_count - base), 0);

        // Random traffic: heavy stall phase then light stall phase.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            writeEn   = 1'($urandom_range(0, 1));
            x_in      = 10'($urandom_range(0, 170));
            y_in      = 10'($urandom_range(0, 125));
            colour    = 3'($urandom_range(0, 7));
            mem_ready = (c < 1500) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 7);
            step();
        end
        writeEn = 0; mem_ready = 1;
        n = 0;
        while (busy && n < 50) begin step(); n++; end
        check("rand_drained", 32'(busy), 0);

`ifdef FB_WRITER_CLEAR_EN
        // Fill from idle with colour 0 and an always-ready port.
        apply_reset();
        bg_colour = 3'b000; mem_ready = 1;
        wr_log.delete(); log_en = 1; done_seen = 0; wr_count = 0;
        clear_req = 1; step(); clear_req = 0;
        n = 0;
        while (!done_seen && n < 20010) begin step(); n++; end
        log_en = 0;
        check("clr_done_seen", 32'(done_seen), 1);
        check("clr_writes", 32'(wr_count), 19200);
        if (wr_log.size() == 19200) begin
            check("clr_first", 32'(wr_log[0]),     32'({15'd0, 3'd0}));
            check("clr_last",  32'(wr_log[19199]), 32'({15'd19199, 3'd0}));
        end else check("clr_log_size", 32'(wr_log.size()), 19200);
        step();
        #1;
        check("clr_idle_busy", 32'(busy), 0);

        // Fill requested mid-drain, pixel pushed mid-fill, repeat request ignored.
        bg_colour = 3'b101; mem_ready = 0;
        wr_log.delete(); log_en = 1; done_seen = 0;
        strobe(1, 0, 1);
        strobe(2, 0, 3);
        clear_req = 1; step(); clear_req = 0;
        step();
        mem_ready = 1; step();
        n = 0;
        while (!done_seen && n < 40000) begin
            mem_ready = ($urandom_range(0, 9) < 7);
            if (n == 100) begin writeEn = 1; x_in = 10'd7; y_in = 10'd1; colour = 3'd6; end
            if (n == 200) clear_req = 1;
            step();
            writeEn = 0; clear_req = 0;
            n++;
        end
        check("clr2_done_seen", 32'(done_seen), 1);
        mem_ready = 1;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        log_en = 0;
        check("clr2_log_size", 32'(wr_log.size()), 19203);
        if (wr_log.size() == 19203) begin
            check("clr2_head_first", 32'(wr_log[0]),     32'({15'd1, 3'd1}));
            check("clr2_fill_last",  32'(wr_log[19200]), 32'({15'd19199, 3'd5}));
            check("clr2_pix_a",      32'(wr_log[19201]), 32'({15'd2, 3'd3}));
            check("clr2_pix_b",      32'(wr_log[19202]), 32'({15'd167, 3'd6}));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
